// File: rtl/tanimoto_cmp.sv
// Tanimoto threshold comparator: aligns |A|, |B|, |A&B| sums in capture FIFOs, then tests c*DEN >= NUM*(a+b-c).
// 3-cycle latency from the last capture to o_Valid; there is no backpressure, so a push into a full FIFO is dropped and flagged.

module tanimoto_cmp_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         empty,
  output logic         full,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // a pop in the same cycle frees the slot, so push on full is still accepted
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

module tanimoto_cmp #(
  parameter int SUM_WIDTH  = 16,
  parameter int THR_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [SUM_WIDTH-1:0] i_RefSum,
  input  logic                 i_RefSumNew,
  input  logic [SUM_WIDTH-1:0] i_CmpSum,
  input  logic                 i_CmpSumNew,
  input  logic [SUM_WIDTH-1:0] i_AndSum,
  input  logic                 i_AndSumNew,
  input  logic [THR_WIDTH-1:0] i_ThrNum,
  input  logic [THR_WIDTH-1:0] i_ThrDen,
  output logic                 o_Valid,
  output logic                 o_Match,
  output logic [IDX_WIDTH-1:0] o_Idx,
  output logic                 o_Overflow
);
  localparam int DW = SUM_WIDTH + 1;
  localparam int LW = SUM_WIDTH + THR_WIDTH;
  localparam int RW = SUM_WIDTH + 1 + THR_WIDTH;

  logic [SUM_WIDTH-1:0] ref_dat, cmp_dat, and_dat;
  logic                 ref_empty, cmp_empty, and_empty;
  logic                 ref_full, cmp_full, and_full;
  logic                 ref_drop, cmp_drop, and_drop;
  logic                 pop;

  assign pop = !ref_empty && !cmp_empty && !and_empty;

  tanimoto_cmp_fifo #(.W(SUM_WIDTH), .DEPTH(FIFO_DEPTH)) u_ref_fifo (
    .clk(clk), .rstn(rstn), .push(i_RefSumNew), .push_dat(i_RefSum), .pop(pop),
    .pop_dat(ref_dat), .empty(ref_empty), .full(ref_full), .drop(ref_drop)
  );
  tanimoto_cmp_fifo #(.W(SUM_WIDTH), .DEPTH(FIFO_DEPTH)) u_cmp_fifo (
    .clk(clk), .rstn(rstn), .push(i_CmpSumNew), .push_dat(i_CmpSum), .pop(pop),
    .pop_dat(cmp_dat), .empty(cmp_empty), .full(cmp_full), .drop(cmp_drop)
  );
  tanimoto_cmp_fifo #(.W(SUM_WIDTH), .DEPTH(FIFO_DEPTH)) u_and_fifo (
    .clk(clk), .rstn(rstn), .push(i_AndSumNew), .push_dat(i_AndSum), .pop(pop),
    .pop_dat(and_dat), .empty(and_empty), .full(and_full), .drop(and_drop)
  );

  logic                 s1_vld;
  logic [SUM_WIDTH-1:0] s1_a, s1_b, s1_c;
  logic [THR_WIDTH-1:0] s1_num, s1_den;
  logic [DW-1:0]        s1_d;
  logic                 s2_vld;
  logic [LW-1:0]        s2_l;
  logic [RW-1:0]        s2_r;
  logic [IDX_WIDTH-1:0] res_cnt;

  // union size a+b-c needs the extra bit: a=b=max, c=0 must not truncate
  assign s1_d = {1'b0, s1_a} + {1'b0, s1_b} - {1'b0, s1_c};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld     <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_c       <= '0;
      s1_num     <= '0;
      s1_den     <= '0;
      s2_vld     <= 1'b0;
      s2_l       <= '0;
      s2_r       <= '0;
      o_Valid    <= 1'b0;
      o_Match    <= 1'b0;
      o_Idx      <= '0;
      res_cnt    <= '0;
      o_Overflow <= 1'b0;
    end else begin
      s1_vld <= pop;
      if (pop) begin
        s1_a   <= ref_dat;
        s1_b   <= cmp_dat;
        s1_c   <= and_dat;
        s1_num <= i_ThrNum;
        s1_den <= i_ThrDen;
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_l <= {{THR_WIDTH{1'b0}}, s1_c} * {{SUM_WIDTH{1'b0}}, s1_den};
        s2_r <= {{THR_WIDTH{1'b0}}, s1_d} * {{DW{1'b0}}, s1_num};
      end
      o_Valid <= s2_vld;
      if (s2_vld) begin
        o_Match <= ({1'b0, s2_l} >= s2_r);
        o_Idx   <= res_cnt;
        res_cnt <= res_cnt + 1'b1;
      end
      if (ref_drop || cmp_drop || and_drop) o_Overflow <= 1'b1;
    end
  end
endmodule
